// File: rtl/gs232c_rr_issue_arbiter_pkg.sv
// Shared types and helpers for the round-robin issue arbiter.
// Widths here are the maximum supported size; modules zero-extend narrower vectors.
package gs232c_arb_pkg;

  localparam int N_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_LOG2-1:0] onehot2bin(input logic [N-1:0] oh);
    logic [N_LOG2-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | N_LOG2'(i);
    end
    return b;
  endfunction

  // Bits strictly above ptr are set; these get first priority in the search.
  function automatic logic [N-1:0] bin2thermo(input logic [N_LOG2-1:0] ptr);
    logic [N-1:0] th;
    for (int i = 0; i < N; i++) begin
      th[i] = (i > int'(ptr));
    end
    return th;
  endfunction

endpackage

// File: rtl/gs232c_rr_first_find.sv
// Combinational masked first-find: lowest eligible bit above ptr, else lowest
// bit at or below ptr, so ptr itself is searched last.
module gs232c_rr_first_find
  import gs232c_arb_pkg::*;
#(
  parameter int n = 3
) (
  input  logic [(1<<n)-1:0] elig,
  input  logic [n-1:0]      ptr,
  output logic              found,
  output logic [(1<<n)-1:0] win_onehot,
  output logic [n-1:0]      win_idx
);

  localparam int NR = 1 << n;

  logic [N-1:0]      eligExt;
  logic [N-1:0]      hiMask;
  logic [N-1:0]      hiVec;
  logic [N-1:0]      loVec;
  logic [N-1:0]      pickVec;
  logic [N-1:0]      pickOh;
  logic [N_LOG2-1:0] ptrExt;
  logic [N_LOG2-1:0] idxFull;

  always_comb begin
    eligExt          = '0;
    eligExt[NR-1:0]  = elig;
    ptrExt           = '0;
    ptrExt[n-1:0]    = ptr;
    hiMask           = bin2thermo(ptrExt);
    hiVec            = eligExt & hiMask;
    loVec            = eligExt & ~hiMask;
    pickVec          = (|hiVec) ? hiVec : loVec;
    // Two's-complement trick isolates the lowest set bit.
    pickOh           = pickVec & (-pickVec);
    idxFull          = onehot2bin(pickOh);
    found            = |eligExt;
    win_onehot       = pickOh[NR-1:0];
    win_idx          = idxFull[n-1:0];
  end

endmodule

// File: rtl/gs232c_rr_issue_arbiter.sv
// Round-robin arbiter for one issue port: registered one-hot grant held until
// accepted, withdrawn or flushed, with back-to-back re-arbitration on accept.
module gs232c_rr_issue_arbiter
  import gs232c_arb_pkg::*;
#(
  parameter int n = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [(1<<n)-1:0] req,
  input  logic [(1<<n)-1:0] mask,
  input  logic              flush,
  input  logic              grant_ready,
  output logic              grant_valid,
  output logic [(1<<n)-1:0] grant_onehot,
  output logic [n-1:0]      grant_idx,
  output logic [n-1:0]      last_ptr
);

  localparam int NR = 1 << n;

  state_e          state_q;
  logic [NR-1:0]   grantOh_q;
  logic [n-1:0]    grantIdx_q;
  logic [n-1:0]    lastPtr_q;

  logic [NR-1:0]   elig;
  logic [NR-1:0]   postElig;
  logic            idleFound;
  logic [NR-1:0]   idleOh;
  logic [n-1:0]    idleIdx;
  logic            postFound;
  logic [NR-1:0]   postOh;
  logic [n-1:0]    postIdx;
  logic            heldReq;

  assign elig     = req & ~mask;
  assign postElig = elig & ~grantOh_q;
  assign heldReq  = req[grantIdx_q];

  gs232c_rr_first_find #(.n(n)) u_idle_find (
    .elig       (elig),
    .ptr        (lastPtr_q),
    .found      (idleFound),
    .win_onehot (idleOh),
    .win_idx    (idleIdx)
  );

  // After an accept the just-served entry is excluded and becomes the pointer.
  gs232c_rr_first_find #(.n(n)) u_post_find (
    .elig       (postElig),
    .ptr        (grantIdx_q),
    .found      (postFound),
    .win_onehot (postOh),
    .win_idx    (postIdx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grantOh_q  <= '0;
      grantIdx_q <= '0;
      lastPtr_q  <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush && idleFound) begin
            state_q    <= GRANT;
            grantOh_q  <= idleOh;
            grantIdx_q <= idleIdx;
          end
        end
        GRANT: begin
          if (flush || !heldReq) begin
            state_q    <= IDLE;
            grantOh_q  <= '0;
            grantIdx_q <= '0;
          end else if (grant_ready) begin
            lastPtr_q <= grantIdx_q;
            if (postFound) begin
              grantOh_q  <= postOh;
              grantIdx_q <= postIdx;
            end else begin
              state_q    <= IDLE;
              grantOh_q  <= '0;
              grantIdx_q <= '0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          grantOh_q  <= '0;
          grantIdx_q <= '0;
        end
      endcase
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_onehot = grantOh_q;
  assign grant_idx    = grantIdx_q;
  assign last_ptr     = lastPtr_q;

endmodule

// File: tb/tb_gs232c_rr_issue_arbiter.sv
// Directed bench for the round-robin issue arbiter with hand-computed expectations.
module tb_gs232c_rr_issue_arbiter;

  localparam int n = 3;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          flush;
  logic          grant_ready;
  logic          grant_valid;
  logic [N-1:0]  grant_onehot;
  logic [n-1:0]  grant_idx;
  logic [n-1:0]  last_ptr;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  gs232c_rr_issue_arbiter #(.n(n)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .mask         (mask),
    .flush        (flush),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .last_ptr     (last_ptr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then advance one rising edge and settle on the falling edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] m,
                               input logic f, input logic rdy);
    req         = r;
    mask        = m;
    flush       = f;
    grant_ready = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkGrant(input string tag, input logic v, input int idx, input int lp);
    logic [N-1:0] expOh;
    expOh = v ? (8'd1 << idx) : 8'd0;
    checkOutput({tag, ".valid"}, 32'(grant_valid), 32'(v));
    checkOutput({tag, ".idx"}, 32'(grant_idx), v ? 32'(idx) : 32'd0);
    checkOutput({tag, ".onehot"}, 32'(grant_onehot), 32'(expOh));
    checkOutput({tag, ".last"}, 32'(last_ptr), 32'(lp));
  endtask

  initial begin
    reset       = 1'b1;
    req         = '0;
    mask        = '0;
    flush       = 1'b0;
    grant_ready = 1'b0;
    @(negedge clock);
    checkGrant("reset", 1'b0, 0, 7);
    @(negedge clock);
    reset = 1'b0;

    // Full contention: 0..7 then wrap to 0, pointer trailing by one.
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1);
    checkGrant("full0", 1'b1, 0, 7);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1);
      checkGrant($sformatf("full%0d", k), 1'b1, k % 8, k - 1);
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkGrant("fullDrain", 1'b0, 0, 7);

    // Wrap with the pointer entry itself searched last.
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b1);
    checkGrant("setPtr5a", 1'b1, 5, 7);
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b1);
    checkGrant("setPtr5b", 1'b0, 0, 5);
    applyStimulus(8'h21, 8'h00, 1'b0, 1'b0);
    checkGrant("wrap0", 1'b1, 0, 5);
    applyStimulus(8'h21, 8'h00, 1'b0, 1'b1);
    checkGrant("wrap5", 1'b1, 5, 0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkGrant("wrapDrain", 1'b0, 0, 0);

    // Hold under backpressure while req and mask change.
    applyStimulus(8'h08, 8'h00, 1'b0, 1'b0);
    checkGrant("hold3", 1'b1, 3, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'hF8, 8'h08, 1'b0, 1'b0);
      checkGrant($sformatf("held%0d", k), 1'b1, 3, 0);
    end
    applyStimulus(8'hF8, 8'h08, 1'b0, 1'b1);
    checkGrant("holdFire", 1'b1, 4, 3);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkGrant("holdDrain", 1'b0, 0, 3);

    // Withdraw, then flush with ready high, then flush while idle.
    applyStimulus(8'h04, 8'h00, 1'b0, 1'b0);
    checkGrant("wdGrant", 1'b1, 2, 3);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkGrant("withdraw", 1'b0, 0, 3);
    applyStimulus(8'h04, 8'h00, 1'b0, 1'b0);
    checkGrant("flGrant", 1'b1, 2, 3);
    applyStimulus(8'h04, 8'h00, 1'b1, 1'b1);
    checkGrant("flush", 1'b0, 0, 3);
    applyStimulus(8'h04, 8'h00, 1'b1, 1'b1);
    checkGrant("flushIdle", 1'b0, 0, 3);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

    // Mask filtering alternates 1,3; unmasking while 3 is held lets 0 win next.
    applyStimulus(8'h80, 8'h00, 1'b0, 1'b1);
    checkGrant("setPtr7a", 1'b1, 7, 3);
    applyStimulus(8'h80, 8'h00, 1'b0, 1'b1);
    checkGrant("setPtr7b", 1'b0, 0, 7);
    applyStimulus(8'h0F, 8'h05, 1'b0, 1'b1);
    checkGrant("mask1a", 1'b1, 1, 7);
    applyStimulus(8'h0F, 8'h05, 1'b0, 1'b1);
    checkGrant("mask3a", 1'b1, 3, 1);
    applyStimulus(8'h0F, 8'h05, 1'b0, 1'b1);
    checkGrant("mask1b", 1'b1, 1, 3);
    applyStimulus(8'h0F, 8'h05, 1'b0, 1'b1);
    checkGrant("mask3b", 1'b1, 3, 1);
    applyStimulus(8'h0F, 8'h00, 1'b0, 1'b0);
    checkGrant("maskHold", 1'b1, 3, 1);
    applyStimulus(8'h0F, 8'h00, 1'b0, 1'b1);
    checkGrant("unmask0", 1'b1, 0, 3);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkGrant("maskDrain", 1'b0, 0, 3);

    // Asynchronous reset in the middle of an outstanding grant.
    applyStimulus(8'h10, 8'h00, 1'b0, 1'b0);
    checkGrant("preReset", 1'b1, 4, 3);
    #2 reset = 1'b1;
    #1 checkGrant("asyncReset", 1'b0, 0, 7);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'h10, 8'h00, 1'b0, 1'b0);
    checkGrant("postReset", 1'b1, 4, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gs232c_rr_issue_arbiter.md
Name: gs232c_rr_issue_arbiter

Overview:
- Round-robin arbiter sharing one issue/execute port between 2^n requesters (issue-queue entries or FU clients).
- Uses masked first-find priority selection. The search starts at the entry after the last winner, wraps around, and includes the last winner itself as lowest priority.
- Presents a registered one-hot grant with valid/ready handshake. Holds the grant stable until accepted, withdrawn or flushed.

Parameters:
- n, 3, log2 of requester count; N = 1<<n; legal 1..3.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester pending request, level.
- mask  input  N  1 = requester ineligible for new decisions (busy FU, etc.).
- flush  input  1  drop any outstanding grant; no new decision this cycle.
- grant_ready  input  1  downstream accepts the granted request this cycle.
- grant_valid  output  1  a grant is outstanding.
- grant_onehot  output  N  one-hot winner; zero when grant_valid=0.
- grant_idx  output  n  binary winner index; 0 when grant_valid=0.
- last_ptr  output  n  index of the last accepted winner (round-robin pointer).

Behaviour:
- Reset (async, immediate): grant_valid=0, grant_onehot=0, grant_idx=0, last_ptr=N-1, so the first search starts at entry 0. state=IDLE.
- Eligibility: elig = req & ~mask.
- Winner: first set bit of elig scanning last_ptr+1, last_ptr+2, ... mod N, ending with last_ptr itself.
- Implementation of the winner search: split elig into hi = bits above last_ptr and lo = bits at or below last_ptr. If any hi bit is set, take the lowest hi bit; otherwise take the lowest lo bit.
- All outputs are registered. A decision made from inputs in cycle t appears on the outputs in cycle t+1.
- fire = grant_valid & grant_ready & req[grant_idx] & ~flush.
- States:
  - IDLE: grant_valid=0.
    - flush=1 -> stay IDLE.
    - else elig!=0 -> GRANT with the winner.
    - else stay IDLE.
  - GRANT: grant_valid=1. Outputs are frozen until one of the following, evaluated in priority order:
    - flush=1 -> IDLE; last_ptr unchanged.
    - req[grant_idx]=0 (withdraw) -> IDLE; last_ptr unchanged; one bubble cycle.
    - fire -> last_ptr<=grant_idx. Re-arbitrate the same cycle using elig & ~grant_onehot, with the pointer taken as grant_idx. Non-empty -> stay GRANT with the new winner (back-to-back, one grant per cycle). Empty -> IDLE.
    - else (ready=0) -> hold the grant.
- mask and new req arrivals never revoke or alter a held grant. They affect only the next decision.
- flush and fire in the same cycle: flush wins; the transfer is not counted.
- N=2 (n=1): the pointer toggles; two requesters alternate.
- grant_onehot always equals the decode of grant_idx when valid. At most one bit is set.
- Fairness: with all N requesters continuously eligible and ready=1, every requester is granted exactly once in any N consecutive fires.

Decomposition:
- Shared package gs232c_arb_pkg:
  - localparams N, IDLE=1'b0, GRANT=1'b1;
  - function onehot2bin;
  - function bin2thermo (produces the "bits above ptr" mask).
- One sub-module gs232c_rr_first_find:
  - combinational, parameter n;
  - inputs elig[N] and ptr[n];
  - outputs found, win_onehot[N], win_idx[n].
  - Instantiated twice: once for the IDLE decision and once for the post-fire decision. Alternatively instantiated once with a muxed input vector and pointer.

Test Plan:
- Reset mid-GRANT: req=8'h10, grant outstanding, reset pulsed -> outputs zero immediately (async). After release: last_ptr=7, and the next grant goes to idx 4 one cycle after req is seen.
- Full contention: n=3, req=8'hFF, mask=0, ready=1 -> grant_idx sequence 0,1,2,...,7,0 on consecutive cycles, grant_valid constant 1, last_ptr trails by one.
- Wrap plus included pointer: last_ptr=5, req=8'h21 -> grant idx 0. After it fires with req=8'h20 remaining -> grant idx 5.
- Hold under backpressure: grant idx 3, ready=0 for 4 cycles while req changes to 8'hF8 and mask[3] rises -> idx 3 held unchanged. ready=1 -> fire, next grant idx 4.
- Withdraw and flush: grant idx 2 then req[2] drops -> IDLE next cycle, last_ptr unchanged. Separately, flush with ready=1 -> no fire, IDLE, last_ptr unchanged.
- Mask filtering: req=8'h0F, mask=8'h05, last_ptr=7 -> grants 1,3,1,3... Clearing the mask while idx 3 is held -> next grant goes to idx 0.
